// File: rtl/rgb_pwm_capture.sv
// Per-channel duty / edge / stuck monitor for the RGB LED PWM pins over fixed clk windows.
// Pin-to-act latency 2 clk; results update on the window-closing edge with a 1-cycle valid, no backpressure.
module rgb_pwm_capture #(
  parameter int WINDOW     = 12000,
  parameter int CNT_W      = 14,
  parameter int EDGE_W     = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rgb_r_in,
  input  logic              rgb_g_in,
  input  logic              rgb_b_in,
  output logic [CNT_W-1:0]  on_r,
  output logic [CNT_W-1:0]  on_g,
  output logic [CNT_W-1:0]  on_b,
  output logic [EDGE_W-1:0] edges_r,
  output logic [EDGE_W-1:0] edges_g,
  output logic [EDGE_W-1:0] edges_b,
  output logic [2:0]        stuck,
  output logic              valid
);

  localparam int                WCNT_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int                EW1      = EDGE_W + 1;
  localparam logic [WCNT_W-1:0] WLAST    = WCNT_W'(WINDOW - 1);
  localparam logic [2:0]        IDLE_LVL = {3{ACTIVE_LOW}};

  logic [2:0]        pin;
  logic [2:0]        act;
  logic [2:0]        rise;
  logic [2:0]        sync1_q;
  logic [2:0]        sync2_q;
  logic [2:0]        act_prev_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W-1:0] wcnt_d;
  logic              win_end;
  logic [2:0]        stuck_q;
  logic [2:0]        stuck_d;
  logic              valid_q;
  logic              valid_d;

  logic [CNT_W-1:0]  on_acc_q   [3];
  logic [CNT_W-1:0]  on_acc_d   [3];
  logic [CNT_W-1:0]  on_out_q   [3];
  logic [CNT_W-1:0]  on_out_d   [3];
  logic [CNT_W-1:0]  on_sum     [3];
  logic [EDGE_W-1:0] edge_acc_q [3];
  logic [EDGE_W-1:0] edge_acc_d [3];
  logic [EDGE_W-1:0] edge_out_q [3];
  logic [EDGE_W-1:0] edge_out_d [3];
  logic [EDGE_W-1:0] edge_sat   [3];
  logic [EW1-1:0]    edge_sum   [3];

  assign pin     = {rgb_b_in, rgb_g_in, rgb_r_in};
  assign act     = sync2_q ^ IDLE_LVL;
  assign rise    = act & ~act_prev_q;
  assign win_end = enable && (wcnt_q == WLAST);

  // Current-cycle contribution folded in, so a closing window includes its last cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      on_sum[i]   = on_acc_q[i] + CNT_W'(act[i]);
      edge_sum[i] = {1'b0, edge_acc_q[i]} + EW1'(rise[i]);
      edge_sat[i] = edge_sum[i][EDGE_W] ? {EDGE_W{1'b1}} : edge_sum[i][EDGE_W-1:0];
    end
  end

  always_comb begin
    wcnt_d  = wcnt_q;
    stuck_d = stuck_q;
    valid_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      on_acc_d[i]   = on_acc_q[i];
      edge_acc_d[i] = edge_acc_q[i];
      on_out_d[i]   = on_out_q[i];
      edge_out_d[i] = edge_out_q[i];
    end
    if (!enable) begin
      wcnt_d = '0;
      for (int i = 0; i < 3; i++) begin
        on_acc_d[i]   = '0;
        edge_acc_d[i] = '0;
      end
    end else if (win_end) begin
      wcnt_d  = '0;
      valid_d = 1'b1;
      for (int i = 0; i < 3; i++) begin
        on_out_d[i]   = on_sum[i];
        edge_out_d[i] = edge_sat[i];
        stuck_d[i]    = (edge_sat[i] == '0);
        on_acc_d[i]   = '0;
        edge_acc_d[i] = '0;
      end
    end else begin
      wcnt_d = wcnt_q + WCNT_W'(1);
      for (int i = 0; i < 3; i++) begin
        on_acc_d[i]   = on_sum[i];
        edge_acc_d[i] = edge_sat[i];
      end
    end
  end

  // Synchronizer and act_prev run regardless of enable so re-enabling sees correct edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= IDLE_LVL;
      sync2_q    <= IDLE_LVL;
      act_prev_q <= '0;
      wcnt_q     <= '0;
      stuck_q    <= '0;
      valid_q    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        on_acc_q[i]   <= '0;
        edge_acc_q[i] <= '0;
        on_out_q[i]   <= '0;
        edge_out_q[i] <= '0;
      end
    end else begin
      sync1_q    <= pin;
      sync2_q    <= sync1_q;
      act_prev_q <= act;
      wcnt_q     <= wcnt_d;
      stuck_q    <= stuck_d;
      valid_q    <= valid_d;
      for (int i = 0; i < 3; i++) begin
        on_acc_q[i]   <= on_acc_d[i];
        edge_acc_q[i] <= edge_acc_d[i];
        on_out_q[i]   <= on_out_d[i];
        edge_out_q[i] <= edge_out_d[i];
      end
    end
  end

  assign on_r    = on_out_q[0];
  assign on_g    = on_out_q[1];
  assign on_b    = on_out_q[2];
  assign edges_r = edge_out_q[0];
  assign edges_g = edge_out_q[1];
  assign edges_b = edge_out_q[2];
  assign stuck   = stuck_q;
  assign valid   = valid_q;

endmodule
